// File: rtl/exp_series_if.sv
// Operand/result bundle for exp_series_engine; master drives the request, slave returns the sum.
// Single-cycle start/done handshake, no backpressure: start is ignored while the engine is busy.
interface exp_series_if #(
   parameter int W         = 16,
   parameter int MAX_TERMS = 8
);
   localparam int TW = $clog2(MAX_TERMS + 1);

   logic          start;
   logic          mode;
   logic [W-1:0]  x;
   logic [W-1:0]  thr;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [TW-1:0] terms;
   logic          ovf;

   modport master (
      output start, mode, x, thr,
      input  busy, done, result, terms, ovf
   );

   modport slave (
      input  start, mode, x, thr,
      output busy, done, result, terms, ovf
   );
endinterface

// File: rtl/exp_series_engine.sv
// Truncated Taylor series e^x / e^-x in unsigned Q(W-F).F, three cycles per term.
// Latency 3k cycles for k terms; start is accepted only in IDLE, never queued.
module exp_series_engine #(
   parameter int W         = 16,
   parameter int F         = 8,
   parameter int MAX_TERMS = 8
) (
   input logic        clk,
   input logic        rst,
   exp_series_if.slave bus
);
   localparam int TW = $clog2(MAX_TERMS + 1);
   localparam int RW = 2 ** TW;

   typedef enum logic [2:0] {IDLE, MULX, MULC, ACC, DONE} state_t;

   state_t        state_q;
   logic [W-1:0]  x_q, thr_q, term_q, acc_q, result_q;
   logic          mode_q, busy_q, done_q, ovf_q;
   logic [TW-1:0] n_q, terms_q;

   // c[n] = round(2^F / n); unused index slots read as zero
   logic [W-1:0] coef_rom [RW];
   for (genvar g = 0; g < RW; g++) begin : g_coef
      if (g >= 1 && g <= MAX_TERMS) begin : g_val
         assign coef_rom[g] = W'(((2 ** (F + 1)) / g + 1) / 2);
      end else begin : g_zero
         assign coef_rom[g] = '0;
      end
   end

   logic [W-1:0]   mul_op;
   logic [2*W-1:0] prod, shifted;
   logic [W-1:0]   mul_d;
   logic           mul_ovf;

   always_comb begin
      mul_op  = (state_q == MULX) ? x_q : coef_rom[n_q];
      prod    = {{W{1'b0}}, term_q} * {{W{1'b0}}, mul_op};
      shifted = prod >> F;
      mul_ovf = |shifted[2*W-1:W];
      mul_d   = mul_ovf ? '1 : shifted[W-1:0];
   end

   logic         subtract, acc_ovf, last;
   logic [W:0]   sum;
   logic [W-1:0] acc_d;

   always_comb begin
      subtract = mode_q & n_q[0];
      sum      = {1'b0, acc_q} + {1'b0, term_q};
      if (subtract) begin
         acc_ovf = term_q > acc_q;
         acc_d   = acc_ovf ? '0 : acc_q - term_q;
      end else begin
         acc_ovf = sum[W];
         acc_d   = sum[W] ? '1 : sum[W-1:0];
      end
      last = (term_q <= thr_q) || (n_q == TW'(MAX_TERMS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         thr_q    <= '0;
         mode_q   <= 1'b0;
         term_q   <= '0;
         acc_q    <= '0;
         n_q      <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         terms_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  x_q     <= bus.x;
                  thr_q   <= bus.thr;
                  mode_q  <= bus.mode;
                  term_q  <= W'(2 ** F);
                  acc_q   <= W'(2 ** F);
                  n_q     <= TW'(1);
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= MULX;
               end
            end
            MULX: begin
               term_q  <= mul_d;
               ovf_q   <= ovf_q | mul_ovf;
               state_q <= MULC;
            end
            MULC: begin
               term_q  <= mul_d;
               ovf_q   <= ovf_q | mul_ovf;
               state_q <= ACC;
            end
            ACC: begin
               acc_q <= acc_d;
               ovf_q <= ovf_q | acc_ovf;
               // result is captured here so it is valid during the done cycle
               if (last) begin
                  result_q <= acc_d;
                  terms_q  <= n_q;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  n_q     <= n_q + TW'(1);
                  state_q <= MULX;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.terms  = terms_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_exp_series_engine.sv
// Scoreboard bench for exp_series_engine (W=16, F=8, MAX_TERMS=8).
module tb_exp_series_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   logic [15:0] last_res = 16'h0000;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  k;
      logic        ov;
      int          c0;
   } exp_t;

   exp_t sb[$];

   exp_series_if #(.W(16), .MAX_TERMS(8)) bus ();

   exp_series_engine #(.W(16), .F(8), .MAX_TERMS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural reference of the truncated series
   task automatic model(input logic [15:0] xv, input logic [15:0] thrv, input logic m,
                        output logic [15:0] res, output logic [3:0] k, output logic ov);
      longint term, acc, c;
      term = 256;
      acc  = 256;
      ov   = 1'b0;
      k    = 4'd8;
      for (int n = 1; n <= 8; n++) begin
         term = (term * xv) / 256;
         if (term > 65535) begin term = 65535; ov = 1'b1; end
         c = (512 / n + 1) / 2;
         term = (term * c) / 256;
         if (m && (n % 2 == 1)) begin
            if (term > acc) begin acc = 0; ov = 1'b1; end
            else acc = acc - term;
         end else begin
            acc = acc + term;
            if (acc > 65535) begin acc = 65535; ov = 1'b1; end
         end
         if (term <= thrv || n == 8) begin
            k = 4'(n);
            break;
         end
      end
      res = 16'(acc);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("terms", bus.terms, e.k);
            chk("ovf", bus.ovf, e.ov);
            chk("latency", cyc - e.c0, 3 * e.k);
            chk("busy_at_done", bus.busy, 1'b0);
         end
      end
   end

   task automatic run_op(input logic [15:0] xv, input logic [15:0] thrv, input logic m,
                         input logic [15:0] eres, input logic [3:0] ek, input logic eov,
                         input bit poke);
      exp_t e;
      bit   seen;
      @(negedge clk);
      bus.x     = xv;
      bus.thr   = thrv;
      bus.mode  = m;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = 16'($urandom);
      bus.thr   = 16'($urandom);
      bus.mode  = ~m;
      e.res = eres;
      e.k   = ek;
      e.ov  = eov;
      e.c0  = cyc;
      sb.push_back(e);
      chk("busy_rise", bus.busy, 1'b1);
      chk("result_held", bus.result, last_res);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (poke && i == 3) begin
            bus.start = 1'b1;
            bus.x     = 16'h0800;
         end
         if (poke && i == 4) bus.start = 1'b0;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      last_res = eres;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] rx, rthr, rres;
      logic        rm, rov;
      logic [3:0]  rk;

      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.x     = '0;
      bus.thr   = '0;
      #3;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_result", bus.result, 16'h0000);
      chk("rst_terms", bus.terms, 4'd0);
      chk("rst_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_op(16'h0100, 16'h0000, 1'b0, 16'h02B5, 4'd6, 1'b0, 1'b0);
      run_op(16'h0100, 16'h0000, 1'b1, 16'h005F, 4'd6, 1'b0, 1'b0);
      run_op(16'h0100, 16'h0040, 1'b0, 16'h02AA, 4'd3, 1'b0, 1'b0);
      run_op(16'h0800, 16'h0000, 1'b0, 16'hFFFF, 4'd8, 1'b1, 1'b0);
      run_op(16'h0100, 16'h0100, 1'b0, 16'h0200, 4'd1, 1'b0, 1'b0);
      run_op(16'h0100, 16'h0000, 1'b0, 16'h02B5, 4'd6, 1'b0, 1'b1);

      // abort a run with a one-cycle reset pulse
      @(negedge clk);
      bus.x     = 16'h0100;
      bus.thr   = 16'h0000;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_done", bus.done, 1'b0);
      chk("arst_result", bus.result, 16'h0000);
      chk("arst_terms", bus.terms, 4'd0);
      chk("arst_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      last_res = 16'h0000;
      repeat (25) @(negedge clk);
      chk("arst_idle_busy", bus.busy, 1'b0);
      run_op(16'h0100, 16'h0000, 1'b0, 16'h02B5, 4'd6, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         rx   = 16'($urandom_range(0, 16'h0400));
         rthr = 16'($urandom_range(0, 32));
         rm   = 1'($urandom_range(0, 1));
         model(rx, rthr, rm, rres, rk, rov);
         run_op(rx, rthr, rm, rres, rk, rov, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
